// File: rtl/priority_encoder_pkg.sv
// Shared constants, key bundle type and the combinational priority encode.
package priority_encoder_pkg;

  localparam int NUM_KEYS = 10;
  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] NO_KEY_CODE = 4'd0;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } key_t;

  // Highest index wins; several keys resolve in one step.
  function automatic key_t encode_keys(
    input logic [NUM_KEYS-1:0] k
  );
    key_t r;
    r.valid = 1'b1;
    r.code = NO_KEY_CODE;
    priority case (1'b1)
      k[9]: r.code = 4'd9;
      k[8]: r.code = 4'd8;
      k[7]: r.code = 4'd7;
      k[6]: r.code = 4'd6;
      k[5]: r.code = 4'd5;
      k[4]: r.code = 4'd4;
      k[3]: r.code = 4'd3;
      k[2]: r.code = 4'd2;
      k[1]: r.code = 4'd1;
      k[0]: r.code = 4'd0;
      default: begin
        r.valid = 1'b0;
        r.code = NO_KEY_CODE;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_debouncer.sv
// keypad_debouncer: accepts an encoded key pair once it has been
// unchanged for DEBOUNCE_CYCLES consecutive cycles.
module keypad_debouncer
  import priority_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  key_t raw,
  output key_t stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  key_t          cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] run;

  // run = cycles raw has held its value, including this one
  always_comb begin
    run = CW'(1);
    if (raw == cand) begin
      if (cnt == CNT_MAX) begin
        run = cnt;
      end else begin
        run = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
      cnt <= '0;
      stable <= '0;
    end else begin
      cand <= raw;
      cnt <= run;
      if (run == CNT_MAX) begin
        stable <= raw;
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Synchronized 10-key priority encoder with registered BCD/valid/press.
// Optional debounce stage: define PRIORITY_ENCODER_DEBOUNCE_EN.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enablen,
  output logic [CODE_W-1:0]   D,
  output logic                V,
  output logic                press
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("priority_encoder: bad parameter");
  end

  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] sync_q;
  key_t enc;
  key_t src;
  key_t nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], keypad};
    end
  end

  assign enc = encode_keys(sync_q[SYNC_STAGES-1]);

`ifdef PRIORITY_ENCODER_DEBOUNCE_EN
  keypad_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst   (rst),
    .raw   (enc),
    .stable(src)
  );
`else
  assign src = enc;
`endif

  assign nxt = enablen ? key_t'('0) : src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D <= NO_KEY_CODE;
      V <= 1'b0;
      press <= 1'b0;
    end else begin
      D <= nxt.code;
      V <= nxt.valid;
      press <= nxt.valid && (!V || nxt.code != D);
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: reference model plus
// directed literal checks and a randomized run.
module tb_priority_encoder;

  localparam int S = 2;
  localparam int DB = 4;
`ifdef PRIORITY_ENCODER_DEBOUNCE_EN
  localparam int LAT = S + DB + 1;
`else
  localparam int LAT = S + 1;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] keypad;
  logic       enablen;
  logic [3:0] D;
  logic       V;
  logic       press;

  priority_encoder #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .keypad (keypad),
    .enablen(enablen),
    .D      (D),
    .V      (V),
    .press  (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pc = 0;
  int q[$];
  int st, ev, ed, ep, pv, pd;

  // 16 + index of the highest pressed key, or 0 for no key
  function automatic int enc_model(input logic [9:0] k);
    for (int i = 9; i >= 0; i--) begin
      if (k[i]) return 16 + i;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int last;
    int off;
    bit same;
    if (rst) begin
      q.delete();
      repeat (S + DB + 3) q.push_back(0);
      st = 0; ev = 0; ed = 0; ep = 0; pv = 0; pd = 0;
      return;
    end
    q.push_back(enc_model(keypad));
    if (q.size() > 64) void'(q.pop_front());
    last = q.size() - 1;
`ifdef PRIORITY_ENCODER_DEBOUNCE_EN
    off = S + 1;
    same = 1'b1;
    for (int k = 0; k < DB; k++) begin
      if (q[last-off-k] != q[last-off]) same = 1'b0;
    end
    if (same) st = q[last-off];
`else
    off = S;
    same = 1'b1;
    if (same) st = q[last-off];
`endif
    if (enablen) begin
      ev = 0;
      ed = 0;
    end else begin
      ev = (st >= 16) ? 1 : 0;
      ed = st % 16;
    end
    ep = (ev == 1 && (pv == 0 || ed != pd)) ? 1 : 0;
    pv = ev;
    pd = ed;
  endtask

  // One clock: model at the edge, compare 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("D", int'(D), ed);
    chk("V", int'(V), ev);
    chk("press", int'(press), ep);
    if (press) pc++;
    @(negedge clk);
  endtask

  task automatic settle(input logic [9:0] k);
    keypad = k;
    repeat (LAT + 1) cyc();
  endtask

  int base;
  int hold;
  int r;

  initial begin
    rst = 1'b1;
    keypad = '0;
    enablen = 1'b0;
    q.delete();
    repeat (S + DB + 3) q.push_back(0);
    st = 0; ev = 0; ed = 0; ep = 0; pv = 0; pd = 0;
    repeat (3) cyc();
    chk("reset_D", int'(D), 0);
    chk("reset_V", int'(V), 0);
    chk("reset_press", int'(press), 0);
    rst = 1'b0;

    base = pc;
    settle(10'h200);
    chk("k9_D", int'(D), 9);
    chk("k9_V", int'(V), 1);
    chk("k9_press_cnt", pc - base, 1);

    base = pc;
    settle(10'h100);
    chk("k8_D", int'(D), 8);
    chk("k8_V", int'(V), 1);
    chk("k8_press_cnt", pc - base, 1);
    base = pc;
    settle(10'h000);
    chk("rel_D", int'(D), 0);
    chk("rel_V", int'(V), 0);
    chk("rel_press_cnt", pc - base, 0);

    base = pc;
    settle(10'h001);
    chk("k0_D", int'(D), 0);
    chk("k0_V", int'(V), 1);
    chk("k0_press_cnt", pc - base, 1);
    settle(10'h000);
    chk("k0rel_V", int'(V), 0);

    settle(10'h228);
    chk("m953_D", int'(D), 9);
    settle(10'h028);
    chk("m53_D", int'(D), 5);
    settle(10'h008);
    chk("m3_D", int'(D), 3);

    settle(10'h000);
    enablen = 1'b1;
    settle(10'h020);
    chk("dis_D", int'(D), 0);
    chk("dis_V", int'(V), 0);
    base = pc;
    enablen = 1'b0;
    cyc();
    chk("en_D", int'(D), 5);
    chk("en_V", int'(V), 1);
    repeat (2) cyc();
    chk("en_press_cnt", pc - base, 1);

    settle(10'h080);
    chk("k7_V", int'(V), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_D", int'(D), 0);
    chk("async_V", int'(V), 0);
    chk("async_press", int'(press), 0);
    @(negedge clk);
    repeat (2) cyc();
    rst = 1'b0;
    base = pc;
    repeat (LAT - 1) cyc();
    chk("rst_lat_V", int'(V), 0);
    cyc();
    chk("rst_D", int'(D), 7);
    chk("rst_V", int'(V), 1);
    repeat (2) cyc();
    chk("rst_press_cnt", pc - base, 1);

    settle(10'h000);
    base = pc;
    keypad = 10'h010;
    cyc();
    keypad = 10'h000;
    repeat (LAT + 2) cyc();
`ifdef PRIORITY_ENCODER_DEBOUNCE_EN
    chk("glitch_press_cnt", pc - base, 0);
`else
    chk("glitch_press_cnt", pc - base, 1);
`endif
    chk("glitch_V", int'(V), 0);

    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        repeat ($urandom_range(1, 2)) cyc();
        rst = 1'b0;
      end
      if (hold == 0) begin
        r = $urandom_range(0, 3);
        if (r == 0) keypad = '0;
        else if (r == 1) keypad = 10'(1) << $urandom_range(0, 9);
        else keypad = 10'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) enablen = ~enablen;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/priority_encoder.md
PRIORITY_ENCODER -- requirements
Module: priority_encoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on keypad (minimum 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required when debounce is compiled in (minimum 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 keypad  input  10  key lines 0..9, active-high, asynchronous to clk.
REQ-006 enablen  input  1  active-low enable, synchronous to clk.
REQ-007 D  output  4  registered BCD code of highest-priority pressed key.
REQ-008 V  output  1  registered valid: at least one key pressed while enabled.
REQ-009 press  output  1  one-cycle pulse on a new valid code.

Function
REQ-010 keypad SHALL pass through a SYNC_STAGES-deep flop chain before any decoding.
REQ-011 Priority SHALL be highest index wins: key 9 highest, key 0 lowest.
REQ-012 With enablen=0 and at least one synchronized key high, D SHALL equal the binary index (0..9) of the highest set key, and V SHALL be 1.
REQ-013 With no synchronized key high, D SHALL be 0 and V SHALL be 0; key 0 alone is distinguished from no key only by V.
REQ-014 With enablen=1, D SHALL be 0 and V SHALL be 0 on the next rising edge, regardless of keypad or debounce state.
REQ-015 enablen SHALL NOT be synchronized or debounced; it takes effect one edge after it is sampled.
REQ-016 Without debounce, a keypad change SHALL reach D/V on edge SYNC_STAGES+1 after it is first sampled (latency 3 at default).
REQ-017 press SHALL be 1 for exactly one cycle when V goes 0->1, or when D changes while V stays 1; otherwise press SHALL be 0.
REQ-018 When enablen is released with keys held, the resulting V 0->1 transition SHALL produce press.
REQ-019 D SHALL never exceed 9; codes 10..15 are unreachable.
REQ-020 Simultaneous multiple keys SHALL resolve by REQ-011 in the same cycle, with no intermediate code emitted.

Reset
REQ-021 While rst=1: D=0, V=0, press=0, all synchronizer, debounce and output flops cleared, asynchronously.
REQ-022 After rst falls, outputs SHALL follow full latency from the cleared state; keys held through reset SHALL produce one press when first valid.

Configuration
REQ-023 Macro PRIORITY_ENCODER_DEBOUNCE_EN defined: the encoded {valid, code} pair from the synchronizer SHALL be accepted into D/V only after it is unchanged for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count. Latency = SYNC_STAGES+DEBOUNCE_CYCLES+1.
REQ-024 Macro undefined: no debounce logic; latency per REQ-016; DEBOUNCE_CYCLES is ignored.

Structure
REQ-025 Package priority_encoder_pkg SHALL hold constants NUM_KEYS=10, CODE_W=4 and NO_KEY_CODE=4'd0.
REQ-026 Debounce logic SHALL be a sub-module keypad_debouncer (counter + stable register), instantiated only under PRIORITY_ENCODER_DEBOUNCE_EN.
REQ-027 The priority encode SHALL be a pure combinational function between the synchronizer and the output register.

Verification
REQ-028 Reset, enablen=0, keypad=10'h200 held 5 cycles -> after latency D=9, V=1, one press pulse.
REQ-029 keypad=10'h200 then 10'h100 -> D 9->8, V stays 1, press pulses once on the change; release -> V=0, D=0, no press.
REQ-030 keypad=10'h001 -> D=0, V=1, press once; keypad=10'h000 -> D=0, V=0.
REQ-031 keypad=10'h228 (keys 9, 5, 3) -> D=9; then 10'h028 -> D=5; then 10'h008 -> D=3.
REQ-032 keypad=10'h020 with enablen=1 -> D=0, V=0; enablen to 0 -> D=5, V=1 one edge later, press once.
REQ-033 Assert rst mid-press with key 7 held -> outputs 0 immediately, without a clock edge; deassert -> D=7, V=1 after full latency. With debounce, a 1-cycle glitch on key 4 -> D/V unchanged.
